// File: rtl/operand_feeder_if.sv
// Valid/ready operand stream from the source into the operand feeder FIFO.
interface operand_feeder_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/operand_feeder.sv
// Buffers operand words in a FIFO and issues a programmed burst of them,
// at most one per cycle, to the accumulating adder's addend/Add inputs.
module operand_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  operand_feeder_if.slave        src,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   burst_len,
  output logic [DATA_WIDTH-1:0]  addend,
  output logic                   Add,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_addend;
  logic                  r_add;
  logic                  r_done;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_latch;
  logic                  w_done_nxt;
  logic                  w_ready;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;

  // Ready comes from the registered level alone, so a same-cycle pop never frees a slot.
  assign w_ready      = (r_level != FULL_LVL);
  assign src.in_ready = w_ready;
  assign w_push       = src.in_valid && w_ready;
  assign w_cnt_nxt    = r_cnt + CNT_WIDTH'(1);

  assign addend = r_addend;
  assign Add    = r_add;
  assign done   = r_done;
  assign busy   = (r_state == S_RUN);
  assign level  = r_level;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_latch     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            w_latch     = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (r_level != '0) begin
          w_pop = 1'b1;
          if (w_cnt_nxt == r_len) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FIFO storage carries no reset; emptiness is defined by the pointers and level.
  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wr_ptr] <= src.in_data;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_len <= '0;
      r_cnt <= '0;
    end else if (w_latch) begin
      r_len <= burst_len;
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Addend holds its last value through starvation gaps; only Add drops.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_addend <= '0;
      r_add    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_add  <= w_pop;
      r_done <= w_done_nxt;
      if (w_pop) r_addend <= r_mem[r_rd_ptr];
    end
  end

endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder with a small downstream accumulator model.
module tb_operand_feeder;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int CW = 16;

  logic                  Clk;
  logic                  Rst;
  logic                  start;
  logic [CW-1:0]         burst_len;
  logic [DW-1:0]         addend;
  logic                  Add;
  logic                  busy;
  logic                  done;
  logic [$clog2(DEPTH):0] level;
  logic                  sum_clr;
  logic [DW-1:0]         sum;

  int total = 0;
  int bad   = 0;

  operand_feeder_if #(.DATA_WIDTH(DW)) src ();

  operand_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .Clk(Clk), .Rst(Rst), .src(src), .start(start), .burst_len(burst_len),
    .addend(addend), .Add(Add), .busy(busy), .done(done), .level(level)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Downstream accumulating adder sharing the reset.
  always @(posedge Clk or posedge Rst) begin
    if (Rst)          sum <= '0;
    else if (sum_clr) sum <= '0;
    else if (Add)     sum <= sum + addend;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst = 1'b1; start = 1'b0; burst_len = '0; sum_clr = 1'b0;
    src.in_valid = 1'b0; src.in_data = '0;

    // Reset
    step();
    chk("rst_addend", addend, 0);
    chk("rst_add", Add, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_level", level, 0);
    Rst = 1'b0;
    #1;
    chk("rst_in_ready", src.in_ready, 1);

    // Basic burst 1..4
    for (int i = 1; i <= 4; i++) begin
      src.in_valid = 1'b1; src.in_data = DW'(i);
      step();
    end
    src.in_valid = 1'b0;
    chk("basic_level4", level, 4);
    chk("basic_idle_add", Add, 0);
    start = 1'b1; burst_len = 16'd4;
    step();
    start = 1'b0;
    chk("basic_busy", busy, 1);
    chk("basic_no_add_yet", Add, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("basic_add", Add, 1);
      chk("basic_addend", addend, i);
      chk("basic_done", done, (i == 4));
    end
    chk("basic_busy_end", busy, 0);
    chk("basic_level0", level, 0);
    step();
    chk("basic_add_low", Add, 0);
    chk("basic_done_low", done, 0);
    chk("basic_sum", sum, 10);

    // Full FIFO with a 9th word held
    sum_clr = 1'b1; step(); sum_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("full_ready_before", src.in_ready, 1);
      src.in_valid = 1'b1; src.in_data = 32'h10 + DW'(i);
      step();
    end
    src.in_data = 32'h18;
    chk("full_level8", level, 8);
    chk("full_ready0", src.in_ready, 0);
    step();
    chk("full_hold_level", level, 8);
    start = 1'b1; burst_len = 16'd8;
    step();
    start = 1'b0;
    chk("full_run_level", level, 8);
    chk("full_run_ready0", src.in_ready, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 1) src.in_valid = 1'b0;
      chk("full_add", Add, 1);
      chk("full_addend", addend, 32'h10 + DW'(i));
      chk("full_done", done, (i == 7));
      if (i == 0) chk("full_lvl_after_pop", level, 7);
      if (i == 1) chk("full_lvl_push_pop", level, 7);
    end
    chk("full_level_left", level, 1);
    step();
    chk("full_sum", sum, 32'h9C);

    // Zero-length burst
    start = 1'b1; burst_len = '0;
    step();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_add", Add, 0);
    chk("zero_busy", busy, 0);
    step();
    chk("zero_done_pulse", done, 0);
    chk("zero_add2", Add, 0);
    chk("zero_level", level, 1);

    // Length-1 burst drains the held 9th word
    start = 1'b1; burst_len = 16'd1;
    step();
    start = 1'b0;
    step();
    chk("one_add", Add, 1);
    chk("one_addend", addend, 32'h18);
    chk("one_done", done, 1);
    chk("one_busy", busy, 0);
    step();
    chk("one_level", level, 0);

    // Starvation: one word of 5 every third cycle
    sum_clr = 1'b1;
    start = 1'b1; burst_len = 16'd3;
    step();
    sum_clr = 1'b0; start = 1'b0;
    chk("starve_busy0", busy, 1);
    for (int c = 0; c < 9; c++) begin
      src.in_valid = (c % 3 == 0); src.in_data = 32'd5;
      step();
      chk("starve_add", Add, (c % 3 == 1));
      chk("starve_done", done, (c == 7));
      chk("starve_busy", busy, (c < 7));
      chk("starve_addend", addend, (c == 0) ? 32'h18 : 32'd5);
    end
    src.in_valid = 1'b0;
    chk("starve_sum", sum, 15);
    chk("starve_level", level, 0);

    // Reset mid-burst
    for (int i = 0; i < 5; i++) begin
      src.in_valid = 1'b1; src.in_data = 32'd7 + DW'(i);
      step();
    end
    src.in_valid = 1'b0;
    start = 1'b1; burst_len = 16'd5;
    step();
    start = 1'b0;
    step();
    chk("abort_add1", addend, 7);
    step();
    chk("abort_add2", addend, 8);
    Rst = 1'b1;
    #1;
    chk("abort_addend", addend, 0);
    chk("abort_add", Add, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_level", level, 0);
    chk("abort_sum", sum, 0);
    step();
    Rst = 1'b0;
    step();
    chk("abort_no_done", done, 0);
    chk("abort_ready", src.in_ready, 1);
    for (int i = 3; i <= 4; i++) begin
      src.in_valid = 1'b1; src.in_data = DW'(i);
      step();
    end
    src.in_valid = 1'b0;
    start = 1'b1; burst_len = 16'd2;
    step();
    start = 1'b0;
    step();
    chk("post_addend1", addend, 3);
    step();
    chk("post_addend2", addend, 4);
    chk("post_done", done, 1);
    step();
    chk("post_sum", sum, 7);
    chk("post_level", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_feeder.md
Name: operand_feeder

Overview:
- Upstream stage of the accumulating adder.
- Buffers incoming operand words from a valid/ready source in a small FIFO.
- Issues a programmed number of them to the adder's addend/Add inputs, at most one per cycle.
- Reports busy, a one-cycle done pulse, and FIFO fill level so a controller can sequence accumulation bursts.

Parameters:
- DATA_WIDTH, 32, operand width; matches the adder's DATA_WIDTH.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CNT_WIDTH, 16, width of burst length and issue counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_WIDTH  operand word from source.
- in_valid  in  1  source has a word on in_data.
- in_ready  out  1  FIFO can accept a word this cycle.
- start  in  1  begin a burst; sampled only in IDLE.
- burst_len  in  CNT_WIDTH  number of operands to issue; latched on accepted start.
- addend  out  DATA_WIDTH  operand to adder, registered.
- Add  out  1  addend is valid for accumulation this cycle, registered.
- busy  out  1  burst in progress (state RUN).
- done  out  1  one-cycle pulse marking burst completion.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async, Rst=1):
  - FIFO emptied, level=0, pointers=0.
  - addend=0, Add=0, busy=0, done=0, state=IDLE, issue counter=0.
  - in_ready=1 once Rst is low.
- FIFO:
  - Push on rising edge when in_valid && in_ready.
  - in_ready = (level != DEPTH), derived from registered level only; never depends on in_valid or on a same-cycle pop.
  - Pointers wrap modulo DEPTH.
  - No bypass: a word pushed at edge k is poppable at edge k+1 at the earliest, so Add=1 with that word is visible after edge k+1.
  - Simultaneous push and pop in one cycle leaves level unchanged. Data order is strictly FIFO.
- States: IDLE, RUN.
- IDLE:
  - start=1 with burst_len!=0: latch burst_len, clear issue counter, go to RUN at the next edge; busy=1 from that edge.
  - start=1 with burst_len==0: done=1 for exactly the following cycle, remain in IDLE, no Add.
  - No pops occur in IDLE; pushes continue.
- RUN:
  - Each cycle with level!=0: pop the head word, increment the issue counter.
  - Registered outputs after that edge: addend=word, Add=1.
  - Cycles with level==0 (starvation): Add=0, addend holds its previous value, busy stays 1.
  - On the pop making the issue count equal the latched length: after that edge Add=1, done=1, state=IDLE, busy=0.
  - start is ignored while in RUN.
  - Remaining FIFO words stay buffered for the next burst.
- Add is never high in a cycle where done is low unless state is RUN. Maximum throughput is one Add per cycle, with no bubbles while level>0.
- The issue counter compares against the full CNT_WIDTH latched length; maximum burst = 2^CNT_WIDTH-1.
- Reset mid-burst: immediate abort. Buffered words are discarded and no done pulse is produced. The adder shares Rst, so its sum returns to 0 consistently.
- A pop and a done pulse never occur on consecutive bursts without at least one IDLE cycle, since start is sampled in IDLE.

Test Plan:
- Reset check: assert Rst for 1 clkPeriod -> addend=0, Add=0, busy=0, done=0, level=0, in_ready=1.
- Basic burst: push 1,2,3,4, then start with burst_len=4 -> Add high 4 consecutive cycles with addend 1,2,3,4; done coincides with the 4th; downstream adder sum=10 one cycle later; level=0.
- Full FIFO (DEPTH=8): hold in_valid with 9 distinct words and no start -> in_ready=0 after the 8th accept, level=8, 9th word held. Then start burst_len=8 -> words issue in push order; the 9th is accepted on the cycle after the first pop.
- Starvation: start burst_len=3 on an empty FIFO, push 5 every 3rd cycle -> Add pulses separated by gaps, busy=1 throughout, done on the 3rd Add, final sum=15.
- Zero length: start with burst_len=0 -> single-cycle done, Add never asserted, busy stays 0.
- Reset mid-burst: burst_len=5 with 5 words buffered, assert Rst after 2 Adds -> all outputs and level at reset values, no done. A new 2-word burst afterwards sums correctly from 0.
